// File: rtl/sprite_line_fetcher.sv
// rtl/sprite_line_fetcher.sv - per-scanline sprite ROM fetch scheduler with back/front line buffers
module sprite_line_fetcher #(
  parameter int NUM_SLOTS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   swap,
  input  logic [3:0]             cur_row,
  input  logic [2:0]             cur_line,
  input  logic [4*NUM_SLOTS-1:0] ent_sprite,
  input  logic [2*NUM_SLOTS-1:0] ent_orient,
  input  logic [4*NUM_SLOTS-1:0] ent_row,
  input  logic [4*NUM_SLOTS-1:0] ent_col,
  output logic                   rom_read_enable,
  output logic [3:0]             rom_sprite_ID,
  output logic [1:0]             rom_orientation,
  output logic [2:0]             rom_line_index,
  input  logic [7:0]             rom_data,
  output logic [8*NUM_SLOTS-1:0] line_data,
  output logic [4*NUM_SLOTS-1:0] line_col,
  output logic [NUM_SLOTS-1:0]   line_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]             state;
  logic [IW-1:0]          idx;
  logic [8*NUM_SLOTS-1:0] back_data;
  logic [4*NUM_SLOTS-1:0] back_col;
  logic [NUM_SLOTS-1:0]   back_valid;

  logic [3:0] slot_sprite;
  logic [1:0] slot_orient;
  logic [3:0] slot_row;
  logic [3:0] slot_col;
  logic       fetching;
  logic       hit;

  always_comb begin
    slot_sprite = ent_sprite[{idx, 2'b00} +: 4];
    slot_orient = ent_orient[{idx, 1'b0} +: 2];
    slot_row    = ent_row[{idx, 2'b00} +: 4];
    slot_col    = ent_col[{idx, 2'b00} +: 4];
    fetching    = (state == ST_FETCH);
    hit         = fetching && (slot_sprite != 4'hF) && (slot_row == cur_row);
  end

  // ROM is combinational: address and data live in the same FETCH cycle.
  assign rom_read_enable = hit;
  assign rom_sprite_ID   = fetching ? slot_sprite : 4'hF;
  assign rom_orientation = fetching ? slot_orient : 2'd0;
  assign rom_line_index  = fetching ? cur_line    : 3'd0;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      overrun    <= 1'b0;
      back_data  <= '1;
      back_col   <= '0;
      back_valid <= '0;
      line_data  <= '1;
      line_col   <= '0;
      line_valid <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          back_data[{idx, 3'b000} +: 8] <= hit ? rom_data : 8'hFF;
          back_col[{idx, 2'b00} +: 4]   <= slot_col;
          back_valid[idx]               <= hit;
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase

      // A swap during a pass would expose a half-written back buffer, so it is refused and flagged.
      if (swap) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          line_data  <= back_data;
          line_col   <= back_col;
          line_valid <= back_valid;
        end
      end
    end
  end

endmodule
